// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: instruction classes,
// ALU opcodes, sequencer states and instruction field positions.
package cpu_pkg;

  localparam int INSTR_W = 10;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LDI  = 2'b01;
  localparam logic [1:0] CLS_OUT  = 2'b10;
  localparam logic [1:0] CLS_MISC = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } seq_state_t;

  // Field positions within the 10-bit instruction word.
  localparam int CLS_HI    = 9;
  localparam int CLS_LO    = 8;
  localparam int OP_HI     = 7;
  localparam int OP_LO     = 5;
  localparam int ALU_RD_HI = 3;
  localparam int ALU_RD_LO = 2;
  localparam int RS_HI     = 1;
  localparam int RS_LO     = 0;
  localparam int LDI_RD_HI = 5;
  localparam int LDI_RD_LO = 4;
  localparam int IMM_HI    = 3;
  localparam int IMM_LO    = 0;

  function automatic logic [1:0] instr_cls(input logic [INSTR_W-1:0] w);
    return w[CLS_HI:CLS_LO];
  endfunction

endpackage

// File: rtl/alu_issue_seq_regfile.sv
// Small register file for the ALU issue sequencer: two combinational read
// ports, one clocked write port, all entries cleared on reset.
module seq_regfile #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (we && (waddr == REG_AW'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: decodes instructions, issues ALU ops, writes results
// back and emits register values. Optional zero flag / SKZ via ZERO_FLAG_EN.
module alu_issue_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int NREGS   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              alu_en,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              zero_flag
);

  localparam int REG_AW = $clog2(NREGS);
  localparam int CNT_W  = 2;

  seq_state_t        state_reg, state_next;
  logic [2:0]        op_reg, op_next;
  logic [DATA_W-1:0] in1_reg, in1_next;
  logic [DATA_W-1:0] in2_reg, in2_next;
  logic [REG_AW-1:0] rd_reg, rd_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] res_data_reg, res_data_next;

  logic              accept;
  logic              discard;
  logic              wb;
  logic [1:0]        cls;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [REG_AW-1:0] rf_raddr_a, rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

  assign cls         = instr_cls(instr);
  assign instr_ready = (state_reg == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign wb          = (state_reg == ST_WAIT) && (cnt_reg == '0);
  assign rf_raddr_a  = REG_AW'(instr[ALU_RD_HI:ALU_RD_LO]);
  assign rf_raddr_b  = REG_AW'(instr[RS_HI:RS_LO]);

  seq_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr_a(rf_raddr_a),
    .rdata_a(rf_rdata_a),
    .raddr_b(rf_raddr_b),
    .rdata_b(rf_rdata_b)
  );

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    in1_next      = in1_reg;
    in2_next      = in2_reg;
    rd_next       = rd_reg;
    cnt_next      = cnt_reg;
    res_data_next = res_data_reg;
    rf_we         = 1'b0;
    rf_waddr      = rd_reg;
    rf_wdata      = alu_result;

    case (state_reg)
      ST_IDLE: begin
        if (accept && !discard) begin
          case (cls)
            CLS_ALU: begin
              op_next    = instr[OP_HI:OP_LO];
              in1_next   = rf_rdata_a;
              in2_next   = rf_rdata_b;
              rd_next    = REG_AW'(instr[ALU_RD_HI:ALU_RD_LO]);
              state_next = ST_ISSUE;
            end
            CLS_LDI: begin
              rf_we    = 1'b1;
              rf_waddr = REG_AW'(instr[LDI_RD_HI:LDI_RD_LO]);
              rf_wdata = DATA_W'(instr[IMM_HI:IMM_LO]);
            end
            CLS_OUT: begin
              res_data_next = rf_rdata_b;
              state_next    = ST_EMIT;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        cnt_next   = CNT_W'(ALU_LAT - 1);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wb) begin
          rf_we      = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_EMIT: begin
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= '0;
      in1_reg      <= '0;
      in2_reg      <= '0;
      rd_reg       <= '0;
      cnt_reg      <= '0;
      res_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      in1_reg      <= in1_next;
      in2_reg      <= in2_next;
      rd_reg       <= rd_next;
      cnt_reg      <= cnt_next;
      res_data_reg <= res_data_next;
    end
  end

`ifdef ZERO_FLAG_EN
  logic zf_reg, zf_next;
  logic skip_reg, skip_next;

  // A pending skip swallows the next accepted instruction, whatever its class.
  always_comb begin
    zf_next   = zf_reg;
    skip_next = skip_reg;
    if (wb) zf_next = (alu_result == '0);
    if (accept) begin
      if (skip_reg) begin
        skip_next = 1'b0;
      end else if ((cls == CLS_MISC) && zf_reg) begin
        skip_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_reg   <= 1'b0;
      skip_reg <= 1'b0;
    end else begin
      zf_reg   <= zf_next;
      skip_reg <= skip_next;
    end
  end

  assign zero_flag = zf_reg;
  assign discard   = skip_reg;
`else
  assign zero_flag = 1'b0;
  assign discard   = 1'b0;
`endif

  assign alu_en     = (state_reg == ST_ISSUE);
  assign alu_opcode = op_reg;
  assign alu_in_1   = in1_reg;
  assign alu_in_2   = in2_reg;
  assign res_data   = res_data_reg;
  assign res_valid  = (state_reg == ST_EMIT);

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: one ALU_LAT=1 instance with an ADD/SUB
// model, one ALU_LAT=3 instance fed a per-cycle stamp to check capture timing.
module tb_alu_issue_seq;

`ifdef ZERO_FLAG_EN
  localparam bit ZF_ON = 1'b1;
`else
  localparam bit ZF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] instr = '0;
  logic       instr_valid = 1'b0, instr_valid3 = 1'b0;
  logic       res_ready = 1'b0;

  logic       instr_ready, alu_en, res_valid, zero_flag;
  logic [2:0] alu_opcode;
  logic [3:0] alu_in_1, alu_in_2, alu_result = '0, res_data;

  logic       instr_ready3, alu_en3, res_valid3, zero_flag3;
  logic [2:0] alu_opcode3;
  logic [3:0] alu_in_1_3, alu_in_2_3, res_data3;
  logic [3:0] stamp = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_seq #(.DATA_W(4), .NREGS(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_result(alu_result),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .zero_flag(zero_flag)
  );

  alu_issue_seq #(.DATA_W(4), .NREGS(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid3),
    .instr_ready(instr_ready3), .alu_en(alu_en3), .alu_opcode(alu_opcode3),
    .alu_in_1(alu_in_1_3), .alu_in_2(alu_in_2_3), .alu_result(stamp),
    .res_data(res_data3), .res_valid(res_valid3), .res_ready(res_ready),
    .zero_flag(zero_flag3)
  );

  // Behavioural ALU with one cycle of latency: 0 = ADD, 1 = SUB.
  always @(posedge clk) begin
    if (alu_en) alu_result <= (alu_opcode == 3'd1) ? alu_in_1 - alu_in_2 : alu_in_1 + alu_in_2;
    stamp <= stamp + 4'd1;
  end

  function automatic logic [9:0] f_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    return {2'b00, op, 1'b0, rd, rs};
  endfunction
  function automatic logic [9:0] f_ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {2'b01, 2'b00, rd, imm};
  endfunction
  function automatic logic [9:0] f_out(input logic [1:0] rs);
    return {2'b10, 6'd0, rs};
  endfunction
  localparam logic [9:0] SKZ = 10'b11_0000_0000;

  task automatic send(input bit sel, input logic [9:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (((sel ? instr_ready3 : instr_ready) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_ready_timeout got ready=0 for 50 cycles need 1");
    end
    instr = w;
    if (sel) instr_valid3 = 1'b1; else instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid  = 1'b0;
    instr_valid3 = 1'b0;
  endtask

  task automatic read_out(input bit sel, input logic [1:0] rs, output logic [3:0] d, output logic v);
    send(sel, f_out(rs));
    @(negedge clk);
    d = sel ? res_data3 : res_data;
    v = sel ? res_valid3 : res_valid;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] d;
    logic v;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2, res_valid, res_data, zero_flag, instr_ready3, zero_flag3}
        !== {1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b en=%b op=%h a=%h b=%h rv=%b rd=%h zf=%b need rdy=1 rest 0",
               instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2, res_valid, res_data, zero_flag);
    end
    rst_n = 1'b1;
    read_out(0, 2'd2, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_regfile got valid=%b data=%h need valid=1 data=0", v, d);
    end
    $display("reset: outputs and R2 checked");
  endtask

  task automatic test_add();
    logic [3:0] d;
    logic v;
    send(0, f_ldi(2'd0, 4'd5));
    send(0, f_ldi(2'd1, 4'd3));
    send(0, f_alu(3'd0, 2'd0, 2'd1));
    @(negedge clk);
    checks++;
    if ({alu_en, instr_ready, alu_opcode, alu_in_1, alu_in_2} !== {1'b1, 1'b0, 3'd0, 4'd5, 4'd3}) begin
      errors++;
      $display("FAIL add_issue got en=%b rdy=%b op=%h a=%h b=%h need en=1 rdy=0 op=0 a=5 b=3",
               alu_en, instr_ready, alu_opcode, alu_in_1, alu_in_2);
    end
    @(negedge clk);
    checks++;
    if ({alu_en, instr_ready, alu_in_1, alu_in_2} !== {1'b0, 1'b0, 4'd5, 4'd3}) begin
      errors++;
      $display("FAIL add_wait got en=%b rdy=%b a=%h b=%h need en=0 rdy=0 a=5 b=3",
               alu_en, instr_ready, alu_in_1, alu_in_2);
    end
    @(negedge clk);
    checks++;
    if ({alu_en, instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL add_done got en=%b rdy=%b need en=0 rdy=1", alu_en, instr_ready);
    end
    read_out(0, 2'd0, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd8}) begin
      errors++;
      $display("FAIL add_out got valid=%b data=%h need valid=1 data=8", v, d);
    end
    checks++;
    if ({res_valid, res_data} !== {1'b0, 4'd8}) begin
      errors++;
      $display("FAIL add_out_release got valid=%b data=%h need valid=0 data=8", res_valid, res_data);
    end
    $display("add: 5+3 issued, wrote back 8, emitted %h", d);
  endtask

  task automatic test_backpressure();
    logic [3:0] d;
    logic v;
    send(0, f_out(2'd1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_data, instr_ready} !== {1'b1, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL stall_cycle%0d got valid=%b data=%h rdy=%b need valid=1 data=3 rdy=0",
                 i, res_valid, res_data, instr_ready);
      end
      instr = f_ldi(2'd1, 4'd9);
      instr_valid = (i < 4);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if ({res_valid, instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got valid=%b rdy=%b need valid=0 rdy=1", res_valid, instr_ready);
    end
    read_out(0, 2'd1, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd3}) begin
      errors++;
      $display("FAIL stall_ignored_ldi got valid=%b data=%h need valid=1 data=3", v, d);
    end
    $display("backpressure: 5 stalled cycles, R1 still %h", d);
  endtask

  task automatic test_wrap();
    logic [3:0] d;
    logic v;
    send(0, f_ldi(2'd2, 4'd15));
    send(0, f_ldi(2'd3, 4'd1));
    send(0, f_alu(3'd0, 2'd2, 2'd3));
    read_out(0, 2'd2, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL wrap_out got valid=%b data=%h need valid=1 data=0", v, d);
    end
    checks++;
    if (zero_flag !== ZF_ON) begin
      errors++;
      $display("FAIL wrap_zero_flag got %b need %b", zero_flag, ZF_ON);
    end
    $display("wrap: 15+1 wrote %h, zero_flag=%b", d, zero_flag);
  endtask

  task automatic test_skz();
    logic [3:0] d;
    logic v;
    send(0, SKZ);
    send(0, f_ldi(2'd0, 4'd9));
    send(0, f_ldi(2'd0, 4'd7));
    read_out(0, 2'd0, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd7}) begin
      errors++;
      $display("FAIL skz_r0 got valid=%b data=%h need valid=1 data=7", v, d);
    end
    checks++;
    if (zero_flag !== ZF_ON) begin
      errors++;
      $display("FAIL skz_ldi_keeps_flag got %b need %b", zero_flag, ZF_ON);
    end
    send(0, SKZ);
    send(0, f_ldi(2'd3, 4'd9));
    read_out(0, 2'd3, d, v);
    checks++;
    if ({v, d} !== {1'b1, (ZF_ON ? 4'd1 : 4'd9)}) begin
      errors++;
      $display("FAIL skz_r3 got valid=%b data=%h need valid=1 data=%h", v, d, (ZF_ON ? 4'd1 : 4'd9));
    end
    $display("skz: R0=7, R3=%h", d);
  endtask

  task automatic test_sub_and_alias();
    logic [3:0] d;
    logic v;
    send(0, f_alu(3'd1, 2'd0, 2'd1));
    read_out(0, 2'd0, d, v);
    checks++;
    if ({v, d, zero_flag} !== {1'b1, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL sub_out got valid=%b data=%h zf=%b need valid=1 data=4 zf=0", v, d, zero_flag);
    end
    send(0, f_alu(3'd0, 2'd1, 2'd1));
    @(negedge clk);
    checks++;
    if ({alu_en, alu_in_1, alu_in_2} !== {1'b1, 4'd3, 4'd3}) begin
      errors++;
      $display("FAIL alias_issue got en=%b a=%h b=%h need en=1 a=3 b=3", alu_en, alu_in_1, alu_in_2);
    end
    read_out(0, 2'd1, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd6}) begin
      errors++;
      $display("FAIL alias_out got valid=%b data=%h need valid=1 data=6", v, d);
    end
    send(0, SKZ);
    send(0, f_ldi(2'd2, 4'd6));
    read_out(0, 2'd2, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd6}) begin
      errors++;
      $display("FAIL skz_clear_flag got valid=%b data=%h need valid=1 data=6", v, d);
    end
    $display("sub/alias: 7-3=4, 3+3=6, SKZ with flag clear is harmless");
  endtask

  task automatic test_lat3();
    logic [3:0] d, s;
    logic v;
    s = '0;
    send(1, f_alu(3'd0, 2'd0, 2'd0));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) s = stamp;
      checks++;
      if ({alu_en3, instr_ready3} !== {(k == 1), (k == 5)}) begin
        errors++;
        $display("FAIL lat3_cycle%0d got en=%b rdy=%b need en=%b rdy=%b",
                 k, alu_en3, instr_ready3, (k == 1), (k == 5));
      end
    end
    read_out(1, 2'd0, d, v);
    checks++;
    if ({v, d} !== {1'b1, s + 4'd3}) begin
      errors++;
      $display("FAIL lat3_capture got valid=%b data=%h need valid=1 data=%h", v, d, s + 4'd3);
    end
    $display("lat3: ready low 4 cycles, captured %h", d);
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] d;
    logic v;
    send(0, f_alu(3'd0, 2'd0, 2'd1));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({instr_ready, alu_en} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_in_wait got rdy=%b en=%b need rdy=0 en=0", instr_ready, alu_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_ready, alu_en, res_valid, res_data, alu_opcode, alu_in_1, alu_in_2, zero_flag}
        !== {1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async got rdy=%b en=%b rv=%b rd=%h op=%h a=%h b=%h zf=%b need rdy=1 rest 0",
               instr_ready, alu_en, res_valid, res_data, alu_opcode, alu_in_1, alu_in_2, zero_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_out(0, 2'd0, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL midrst_r0 got valid=%b data=%h need valid=1 data=0", v, d);
    end
    read_out(1, 2'd0, d, v);
    checks++;
    if ({v, d} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL midrst_r0_lat3 got valid=%b data=%h need valid=1 data=0", v, d);
    end
    $display("reset mid-wait: outputs cleared, R0 reads 0");
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_wrap();
    test_skz();
    test_sub_and_alias();
    test_lat3();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish need finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
